psec_spi_burst_regs: RTL
========================

# psec_spi_burst_regs

Parametrised SPI slave register file for the PSEC configuration path: decodes framed serial writes and reads from the off-chip master into a bank of `NUM_REGS` configuration registers, with multi-word bursts and address auto-increment. Write data goes to a flat register bus feeding the clock, channel and test-point blocks. One reserved address produces instruction pulses instead of storing data. Read data returns on `poci_spi` for the readout mux.

## Interface
- `ADDR_W`, 7, address field width in the frame header.
- `DATA_W`, 8, register and word width.
- `NUM_REGS`, 16, implemented registers at addresses 0..NUM_REGS-1; legal range 2..2^ADDR_W.
- `INST_ADDR`, 3, pulse-only instruction address; must be < NUM_REGS.
- `RESET_VAL`, all zeros, NUM_REGS*DATA_W flat reset image; register k is bits [k*DATA_W +: DATA_W].

Ports:
- `spi_clk`  in  1  sole clock; all state changes on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `cs`  in  1  chip select, active-low, sampled on `spi_clk`.
- `pico`  in  1  serial data in, MSB first.
- `poci_spi`  out  1  serial read data, MSB first.
- `addr`  out  ADDR_W  address of the word currently in transfer.
- `regs_flat`  out  NUM_REGS*DATA_W  register contents.
- `wr_strobe`  out  1  one-cycle pulse, high for one cycle after a register commit.
- `inst_pulse`  out  DATA_W  one-cycle pulse vector from a write to INST_ADDR.
- `addr_err`  out  1  sticky flag; set by any access to an address ≥ NUM_REGS.

## Operation
- Frame: `cs` low. Bit 0 is R/W (1 = write). Bits 1..ADDR_W are the start address. Any number of DATA_W-bit data words follows.
- States:
  - IDLE → HDR on first edge with cs=0.
  - HDR → WDATA or RDATA after the last address bit.
  - WDATA/RDATA remain until cs=1, then go to IDLE.
  - Any state → ABORT when rstn is released while cs=0.
  - ABORT → IDLE on cs=1.
- Auto-increment: after each completed word, `addr` = `addr`+1. Address NUM_REGS-1 wraps to 0. An out-of-range start address increments without wrapping until it reaches 2^ADDR_W-1, then wraps to 0.
- Write, in range and ≠ INST_ADDR: register[addr] ← {shift[DATA_W-2:0], pico} on the edge sampling the word's last bit. `wr_strobe` is high the following cycle.
- Write to INST_ADDR:
  - No storage.
  - `inst_pulse` = the received word for exactly one cycle after the commit edge, 0 otherwise.
  - `wr_strobe` is also pulsed.
  - The slot in `regs_flat` stays RESET_VAL.
- Read: returns register[addr]. Reads of INST_ADDR and out-of-range addresses return 0.
- Out-of-range access: writes are ignored, reads return 0, and `addr_err` ← 1 until reset.
- Partial word at cs rise: discarded, no commit, no strobe. The bit counter and shift register clear on the first edge with cs=1.
- Reset values: `regs_flat` = RESET_VAL. `poci_spi`, `addr`, `wr_strobe`, `inst_pulse` and `addr_err` = 0. State = IDLE.

## Timing
- Edge n is the n-th rising edge with cs=0 in a frame, counting from 0.
- The header occupies edges 0..ADDR_W. Word w occupies edges ADDR_W+1+w·DATA_W through ADDR_W+(w+1)·DATA_W.
- `addr` shows the start address from edge ADDR_W+1 onward, and updates on each word's last edge.
- Write latency:
  - `regs_flat` reflects the new value one cycle after the word's last edge.
  - `wr_strobe` and `inst_pulse` are valid in that same cycle.
- Read timing:
  - The shift-out register loads on the last header edge and on each word's last edge (next address).
  - `poci_spi` carries the MSB after that edge and shifts one bit per edge.
  - The master samples on the following rising edge.
- `poci_spi` = 0 in IDLE, HDR and ABORT, and whenever cs=1.
- The master must supply at least 1 `spi_clk` edge with cs=1 between frames.
- rstn=0 overrides everything, including a commit on the same edge. A commit and a cs rise on the same edge cannot occur: cs is sampled first, so cs=1 means no commit.

## Test plan
- Reset with RESET_VAL register 1 = 0x2A → `regs_flat` slice 1 = 0x2A. All other outputs 0.
- Write burst starting at addr 14 with words 0xA1, 0xB2, 0xC3 (NUM_REGS=16) → reg14=0xA1, reg15=0xB2, reg0=0xC3. Three `wr_strobe` pulses DATA_W cycles apart.
- Write 0x05 to INST_ADDR → `inst_pulse`=0x05 for exactly one cycle. reg3 unchanged. Then a read of addr 3 returns 0x00.
- Read burst from addr 1 after writing 0x5A, 0x3C to addr 1 and 2 → `poci_spi` streams 01011010 then 00111100, MSB first, starting the cycle after the last header edge.
- Write to addr 20 → no register changes, `addr_err`=1 and stays set across later frames until rstn=0.
- Raise cs after 5 data bits, then deassert rstn for one edge mid-frame with cs still low → no commit. After the abort, frames are ignored until cs=1. The next full frame works normally.

Source files
------------

// File: rtl/psec_spi_burst_regs.sv
`default_nettype none
// ============================================================================
// psec_spi_burst_regs : SPI slave register bank, burst auto-increment, pulse-only instruction address
// Rev 1.0
// ============================================================================
module psec_spi_burst_regs #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int INST_ADDR = 3,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         spi_clk,
  input  logic                         rstn,
  input  logic                         cs,
  input  logic                         pico,
  output logic                         poci_spi,
  output logic [ADDR_W-1:0]            addr,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [DATA_W-1:0]            inst_pulse,
  output logic                         addr_err
);

  localparam int C_CNT_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int C_CNT_W   = $clog2(C_CNT_MAX);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_HDR   = 3'd1;
  localparam logic [2:0] c_S_WDATA = 3'd2;
  localparam logic [2:0] c_S_RDATA = 3'd3;
  localparam logic [2:0] c_S_ABORT = 3'd4;

  localparam logic [ADDR_W:0]   c_NUM_REGS = NUM_REGS[ADDR_W:0];
  localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] c_INST     = ADDR_W'(INST_ADDR);
  localparam logic [C_CNT_W-1:0] c_HDR_END = C_CNT_W'(ADDR_W - 1);
  localparam logic [C_CNT_W-1:0] c_WRD_END = C_CNT_W'(DATA_W - 1);

  logic [2:0]                   r_state;
  logic [C_CNT_W-1:0]           r_cnt;
  logic                         r_rw;
  logic                         r_rst_seen;
  logic [ADDR_W-2:0]            r_hdr;
  logic [DATA_W-2:0]            r_shift;
  logic [DATA_W-1:0]            r_sout;
  logic [ADDR_W-1:0]            r_addr;
  logic [NUM_REGS*DATA_W-1:0]   r_regs;
  logic                         r_wr_strobe;
  logic [DATA_W-1:0]            r_inst;
  logic                         r_err;

  logic [ADDR_W-1:0] w_hdr_addr;
  logic [DATA_W-1:0] w_word;
  logic              w_last_hdr;
  logic              w_last_word;
  logic              w_in_range;
  logic              w_hdr_in_range;
  logic [ADDR_W-1:0] w_next_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_commit;

  assign w_hdr_addr     = {r_hdr, pico};
  assign w_word         = {r_shift, pico};
  assign w_last_hdr     = (r_state == c_S_HDR) && (r_cnt == c_HDR_END);
  assign w_last_word    = ((r_state == c_S_WDATA) || (r_state == c_S_RDATA)) && (r_cnt == c_WRD_END);
  assign w_in_range     = {1'b0, r_addr} < c_NUM_REGS;
  assign w_hdr_in_range = {1'b0, w_hdr_addr} < c_NUM_REGS;
  // In-range bursts wrap at the top register; out-of-range ones roll over naturally.
  assign w_next_addr    = (r_addr == c_LAST) ? '0 : r_addr + 1'b1;
  assign w_rd_addr      = w_last_hdr ? w_hdr_addr : w_next_addr;
  assign w_commit       = !cs && !r_rst_seen && w_last_word && (r_state == c_S_WDATA) && w_in_range;

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if ((w_rd_addr == ADDR_W'(k)) && (k != INST_ADDR)) begin
        w_rd_word = r_regs[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!rstn) begin
      r_state     <= c_S_IDLE;
      r_cnt       <= '0;
      r_rw        <= 1'b0;
      r_rst_seen  <= 1'b1;
      r_hdr       <= '0;
      r_shift     <= '0;
      r_sout      <= '0;
      r_addr      <= '0;
      r_regs      <= RESET_VAL;
      r_wr_strobe <= 1'b0;
      r_inst      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rst_seen  <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_inst      <= '0;
      if (cs) begin
        r_state <= c_S_IDLE;
        r_cnt   <= '0;
        r_hdr   <= '0;
        r_shift <= '0;
        r_sout  <= '0;
      end else if (r_rst_seen) begin
        // Reset released in the middle of a frame: ignore the rest of it.
        r_state <= c_S_ABORT;
      end else begin
        case (r_state)
          c_S_IDLE: begin
            r_rw    <= pico;
            r_cnt   <= '0;
            r_state <= c_S_HDR;
          end
          c_S_HDR: begin
            r_hdr <= w_hdr_addr[ADDR_W-2:0];
            if (w_last_hdr) begin
              r_state <= r_rw ? c_S_WDATA : c_S_RDATA;
              r_addr  <= w_hdr_addr;
              r_cnt   <= '0;
              r_sout  <= w_rd_word;
              if (!w_hdr_in_range) r_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          c_S_WDATA, c_S_RDATA: begin
            r_shift <= w_word[DATA_W-2:0];
            if (w_last_word) begin
              r_cnt  <= '0;
              r_addr <= w_next_addr;
              r_sout <= w_rd_word;
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_sout <= {r_sout[DATA_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end

      if (w_commit) begin
        r_wr_strobe <= 1'b1;
        if (r_addr == c_INST) r_inst <= w_word;
      end
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_commit && (r_addr == ADDR_W'(k)) && (k != INST_ADDR)) begin
          r_regs[k*DATA_W +: DATA_W] <= w_word;
        end
      end
    end
  end

  assign poci_spi   = (r_state == c_S_RDATA) && !cs && r_sout[DATA_W-1];
  assign addr       = r_addr;
  assign regs_flat  = r_regs;
  assign wr_strobe  = r_wr_strobe;
  assign inst_pulse = r_inst;
  assign addr_err   = r_err;

endmodule
`default_nettype wire
